mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle shift-add multiplier controller for the single-cycle/pipelined CPU. It borrows the shared datapath ALU for the MUL instruction. While a multiply runs it owns the ALU, holds the rest of the pipeline with `stall`, and issues one ADD per cycle to accumulate partial products. It returns the low WIDTH bits of the product with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 64, operand/product width in bits
- `ALU_ADD`, 4'b0010, ALU control code that selects A+B on the shared ALU
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request a multiply; sampled only in IDLE
- `flush`  in  1  synchronous abort; returns to IDLE with no `done`
- `multiplicand`  in  WIDTH  operand A, latched on accepted `start`
- `multiplier`  in  WIDTH  operand B, latched on accepted `start`
- `alu_result`  in  WIDTH  combinational sum returned by the shared ALU in the same cycle
- `alu_own`  out  1  ALU input-mux select; 1 = this block drives ALU A/B/ctrl
- `alu_a`  out  WIDTH  ALU A operand (accumulator)
- `alu_b`  out  WIDTH  ALU B operand (shifted multiplicand)
- `alu_ctrl`  out  4  ALU control code
- `stall`  out  1  freeze PC and pipeline registers
- `busy`  out  1  state == BUSY
- `done`  out  1  one-cycle pulse; `product` is valid
- `product`  out  WIDTH  low WIDTH bits of multiplicand*multiplier; held until next accepted start

## Operation
- **States.** IDLE, BUSY, DONE. Internal registers:
  - `acc` (WIDTH)
  - `mcand` (WIDTH)
  - `mplier` (WIDTH)
- **IDLE**, `start`=1 at an edge:
  - Latch `mcand`=`multiplicand`, `mplier`=`multiplier`, `acc`=0.
  - If `multiplier`==0, go to DONE with `product`=0.
  - Otherwise go to BUSY.
- **BUSY**, every cycle:
  - Drive `alu_own`=1, `alu_a`=`acc`, `alu_b`=`mcand`, `alu_ctrl`=ALU_ADD.
  - At the edge: if `mplier[0]`, `acc`←`alu_result`. Then `mcand`←`mcand`<<1 (MSB dropped) and `mplier`←`mplier`>>1 (zero fill).
  - If the shifted `mplier` is 0, go to DONE and load `product` with the updated `acc` value.
- **DONE:**
  - Drive `done`=1 for exactly one cycle.
  - `alu_own`=0.
  - Go to IDLE unconditionally.
  - `start` is ignored in DONE.
- **Outputs when not owning the ALU:** `alu_a`, `alu_b` and `alu_ctrl` are 0.
- **Stall:** `stall` = (state==BUSY) | (state==IDLE & `start`). This holds the issuing instruction in the same cycle `start` is raised. `stall` is 0 in DONE so the MUL retires.
- **Arithmetic:** unsigned modulo 2^WIDTH. This is identical to the low half of the signed product. No overflow flag.
- **Flush:**
  - `flush`=1 at an edge in any state forces IDLE.
  - `done` is not asserted and `product` is unchanged.
  - `flush` has priority over `start`.
- **Reset:** asynchronous. State=IDLE, `acc`/`mcand`/`mplier`/`product`=0. All outputs 0: `alu_own`, `stall`, `busy`, `done`, `alu_a`, `alu_b`, `alu_ctrl`. Reset mid-BUSY aborts with no `done`.

## Timing
- Let n = index of the highest set bit of `multiplier`, plus 1 (1..WIDTH).
- BUSY lasts n cycles. `done` is high in cycle n+1 after the accepting edge. `multiplier`==0 gives `done` in cycle 1.
- Worst case is `multiplier` MSB set: WIDTH BUSY cycles, WIDTH+1 cycles to `done`.
- `alu_result` is used in the same cycle it is produced. There is no ALU pipeline register inside this block.
- `product` updates on the edge entering DONE and is stable while `done`=1 and afterward.
- Back-to-back: the earliest next accepted `start` is the IDLE cycle following DONE.

## Test plan
- Reset, then `multiplicand`=3, `multiplier`=5, pulse `start`:
  - `busy`/`stall` high for 3 cycles.
  - `alu_ctrl`=0010 while busy.
  - `done` pulses in cycle 4 with `product`=15.
  - `alu_own` returns to 0.
- `multiplier`=0, `multiplicand`=0xFFFF_FFFF_FFFF_FFFF:
  - No BUSY cycles.
  - `done` in cycle 1, `product`=0, `stall` low in DONE.
- Worst case `multiplicand`=2, `multiplier`=0x8000_0000_0000_0000:
  - 64 BUSY cycles.
  - `product`=0 (wrap).
  - `done` on cycle 65.
- `multiplicand`=0xFFFF_FFFF_FFFF_FFFF (-1), `multiplier`=7:
  - `product`=0xFFFF_FFFF_FFFF_FFF9 (-7).
  - 3 BUSY cycles.
- Abort paths:
  - Start 6*9, assert `flush` on the 2nd BUSY cycle: IDLE next cycle, no `done`, `product` retains its prior value.
  - Repeat with async `reset` mid-BUSY: all outputs 0 immediately.
- `start` held high through BUSY and DONE:
  - Ignored until IDLE, then a second multiply is accepted.
  - Exactly one `done` per accepted start.
  - `start` and `flush` together in IDLE: stays IDLE.

Source files
------------

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier that borrows the shared datapath ALU and
// stalls the pipeline while it accumulates partial products one ADD per cycle.
module mul_sequencer #(
  parameter int         WIDTH   = 64,
  parameter logic [3:0] ALU_ADD = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             own_q, own_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = multiplicand;
          mplier_d = multiplier;
          if (multiplier == '0) begin
            state_d   = DONE;
            product_d = '0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (mplier_q[0]) acc_d = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Finish as soon as no set multiplier bits remain, skipping leading zeros.
        if (mplier_d == '0) begin
          state_d   = DONE;
          product_d = acc_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      product_d = product_q;
    end
  end

  assign busy_d = (state_d == BUSY);
  assign done_d = (state_d == DONE);
  assign own_d  = (state_d == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      own_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      own_q     <= own_d;
    end
  end

  // The start term holds the issuing MUL in the very cycle it requests the ALU.
  assign stall    = ~reset & (busy_q | ((state_q == IDLE) & start));
  assign busy     = busy_q;
  assign done     = done_q;
  assign alu_own  = own_q;
  assign alu_a    = own_q ? acc_q   : '0;
  assign alu_b    = own_q ? mcand_q : '0;
  assign alu_ctrl = own_q ? ALU_ADD : 4'b0000;
  assign product  = product_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: arithmetic reference model of the
// shift-add schedule, directed corner cases, random operands and abort paths.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [63:0] multiplicand, multiplier, alu_result;
  logic        alu_own, stall, busy, done;
  logic [63:0] alu_a, alu_b, product;
  logic [3:0]  alu_ctrl;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] last_product;

  always #5 clk = ~clk;

  // Shared ALU: adds only when the ADD code is presented.
  assign alu_result = (alu_ctrl == 4'b0010) ? alu_a + alu_b : alu_a - alu_b;

  mul_sequencer #(.WIDTH(64), .ALU_ADD(4'b0010)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .multiplicand(multiplicand), .multiplier(multiplier), .alu_result(alu_result),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .stall(stall), .busy(busy), .done(done), .product(product)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    multiplicand = '0; multiplier = '0;
    #12;
    checks++;
    if ({busy, stall, alu_own, done, alu_ctrl} !== 8'h00)
      begin failures++; $display("[TB] FAIL reset_flags: got %h expected 00", {busy, stall, alu_own, done, alu_ctrl}); end
    checks++;
    if ((alu_a | alu_b | product) !== 64'h0)
      begin failures++; $display("[TB] FAIL reset_data: got a=%h b=%h p=%h expected 0", alu_a, alu_b, product); end
    @(negedge clk); reset = 1'b0;
    last_product = '0;
    @(negedge clk); #1;
    checks++;
    if ({busy, done, alu_own} !== 3'b000)
      begin failures++; $display("[TB] FAIL idle_after_reset: got %b expected 000", {busy, done, alu_own}); end
  endtask

  task automatic test_multiply_cases();
    logic [63:0] tab_a [5] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd6};
    logic [63:0] tab_b [5] = '{64'd5, 64'd0, 64'h8000_0000_0000_0000, 64'd7, 64'd9};
    logic [63:0] a, b, exp_p, part, exp_a, exp_b, exp_prod;
    logic [7:0]  exp_flags;
    int          n;
    for (int k = 0; k < 21; k++) begin
      if (k < 5) begin
        a = tab_a[k]; b = tab_b[k];
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom} >> $urandom_range(63, 0);
      end
      n = 0;
      for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
      exp_p = a * b;
      part  = '0;
      @(negedge clk); multiplicand = a; multiplier = b; start = 1'b1; #1;
      checks++;
      if ({stall, busy, done} !== 3'b100)
        begin failures++; $display("[TB] FAIL start_stall case%0d: got %b expected 100", k, {stall, busy, done}); end
      for (int c = 1; c <= n + 2; c++) begin
        @(negedge clk); start = 1'b0; #1;
        if (c <= n) begin
          exp_flags = 8'b1110_0010; exp_a = part; exp_b = a << (c - 1); exp_prod = last_product;
        end else if (c == n + 1) begin
          exp_flags = 8'b0001_0000; exp_a = '0; exp_b = '0; exp_prod = exp_p;
        end else begin
          exp_flags = 8'b0000_0000; exp_a = '0; exp_b = '0; exp_prod = exp_p;
        end
        checks++;
        if ({busy, stall, alu_own, done, alu_ctrl} !== exp_flags)
          begin failures++; $display("[TB] FAIL flags case%0d cyc%0d: got %b expected %b", k, c, {busy, stall, alu_own, done, alu_ctrl}, exp_flags); end
        checks++;
        if (alu_a !== exp_a)
          begin failures++; $display("[TB] FAIL alu_a case%0d cyc%0d: got %h expected %h", k, c, alu_a, exp_a); end
        checks++;
        if (alu_b !== exp_b)
          begin failures++; $display("[TB] FAIL alu_b case%0d cyc%0d: got %h expected %h", k, c, alu_b, exp_b); end
        checks++;
        if (product !== exp_prod)
          begin failures++; $display("[TB] FAIL product case%0d cyc%0d: got %h expected %h", k, c, product, exp_prod); end
        if (c <= n && b[c-1]) part = part + (a << (c - 1));
      end
      last_product = exp_p;
    end
  endtask

  task automatic test_flush();
    @(negedge clk); multiplicand = 64'd6; multiplier = 64'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); flush = 1'b1; #1;
    checks++;
    if (busy !== 1'b1)
      begin failures++; $display("[TB] FAIL flush_pre_busy: got %b expected 1", busy); end
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if ({busy, stall, alu_own, done, alu_ctrl} !== 8'h00)
      begin failures++; $display("[TB] FAIL flush_idle: got %h expected 00", {busy, stall, alu_own, done, alu_ctrl}); end
    checks++;
    if (product !== last_product)
      begin failures++; $display("[TB] FAIL flush_product: got %h expected %h", product, last_product); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00)
        begin failures++; $display("[TB] FAIL flush_quiet cyc%0d: got %b expected 00", c, {busy, done}); end
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk); multiplicand = 64'd6; multiplier = 64'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1; reset = 1'b1; #1;
    checks++;
    if ({busy, stall, alu_own, done, alu_ctrl} !== 8'h00)
      begin failures++; $display("[TB] FAIL rst_mid_flags: got %h expected 00", {busy, stall, alu_own, done, alu_ctrl}); end
    checks++;
    if ((alu_a | alu_b | product) !== 64'h0)
      begin failures++; $display("[TB] FAIL rst_mid_data: got a=%h b=%h p=%h expected 0", alu_a, alu_b, product); end
    @(negedge clk); reset = 1'b0;
    last_product = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00)
        begin failures++; $display("[TB] FAIL rst_mid_quiet cyc%0d: got %b expected 00", c, {busy, done}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_flags;
    int         done_count = 0;
    @(negedge clk); multiplicand = 64'd3; multiplier = 64'd5; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 3) begin multiplicand = 64'd4; multiplier = 64'd3; end
      #1;
      case (c)
        1, 2, 3, 6, 7: exp_flags = 8'b1110_0010;
        4, 8:          exp_flags = 8'b0001_0000;
        default:       exp_flags = 8'b0100_0000;
      endcase
      if (done === 1'b1) done_count++;
      checks++;
      if ({busy, stall, alu_own, done, alu_ctrl} !== exp_flags)
        begin failures++; $display("[TB] FAIL b2b_flags cyc%0d: got %b expected %b", c, {busy, stall, alu_own, done, alu_ctrl}, exp_flags); end
      if (c == 4 || c == 8) begin
        checks++;
        if (product !== ((c == 4) ? 64'd15 : 64'd12))
          begin failures++; $display("[TB] FAIL b2b_product cyc%0d: got %h expected %h", c, product, (c == 4) ? 64'd15 : 64'd12); end
      end
    end
    start = 1'b0;
    last_product = 64'd12;
    checks++;
    if (done_count !== 2)
      begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_count); end
  endtask

  task automatic test_start_flush_idle();
    @(negedge clk); multiplicand = 64'd5; multiplier = 64'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0; #1;
    checks++;
    if ({busy, stall, alu_own, done, alu_ctrl} !== 8'h00)
      begin failures++; $display("[TB] FAIL start_flush_flags: got %h expected 00", {busy, stall, alu_own, done, alu_ctrl}); end
    checks++;
    if (product !== last_product)
      begin failures++; $display("[TB] FAIL start_flush_product: got %h expected %h", product, last_product); end
    @(negedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00)
      begin failures++; $display("[TB] FAIL start_flush_quiet: got %b expected 00", {busy, done}); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_multiply_cases();
    test_flush();
    test_reset_mid_busy();
    test_back_to_back();
    test_start_flush_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
